// File: rtl/ip_codma_read_machine_pkg.sv
// Shared CODMA read-machine types: state encoding, size codes and
// their word counts.
package ip_codma_states_pkg;

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
    RD_ASK     = 3'd1,
    RD_GRANTED = 3'd2,
    RD_HANDOFF = 3'd3,
    RD_WAIT_WR = 3'd4,
    RD_UNUSED  = 3'd5
  } read_state_t;

  localparam logic [3:0] SIZE_2W  = 4'd3;
  localparam logic [3:0] SIZE_4W  = 4'd8;
  localparam logic [3:0] SIZE_8W  = 4'd9;
  localparam logic [7:0] WORDS_2W = 8'd2;
  localparam logic [7:0] WORDS_4W = 8'd4;
  localparam logic [7:0] WORDS_8W = 8'd8;

  function automatic logic size_legal(input logic [3:0] code);
    return (code == SIZE_2W) || (code == SIZE_4W) || (code == SIZE_8W);
  endfunction

  // Word count for a size code; 0 for illegal codes.
  function automatic logic [7:0] size_words(input logic [3:0] code);
    case (code)
      SIZE_2W: return WORDS_2W;
      SIZE_4W: return WORDS_4W;
      SIZE_8W: return WORDS_8W;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/ip_codma_read_machine_if.sv
// Shared system bus as seen by the CODMA read machine.
interface BUS_IF;
  logic        req;
  logic        grant;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  size;
  logic        rvalid;
  logic [63:0] rdata;   // low word first
  logic        error;

  modport master (output req, we, addr, size, input grant, rvalid, rdata, error);
  modport slave  (input req, we, addr, size, output grant, rvalid, rdata, error);
endinterface

// File: rtl/ip_codma_read_machine_rd_buffer.sv
// Local data buffer: BUF_WORDS x 32 register file written two words
// at a time, fully visible on a flat read-out bus.
module ip_codma_rd_buffer #(
  parameter int BUF_WORDS = 8,
  parameter int IDX_W     = $clog2(BUF_WORDS)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        wr_en_i,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [63:0]                 wr_data_i,
  output logic [BUF_WORDS-1:0][31:0]  rd_data_o
);

  logic [BUF_WORDS-1:0][31:0] buf_q;

  // Low half lands at wr_idx, high half at the next word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_q <= '0;
    end else if (wr_en_i) begin
      buf_q[wr_idx_i]                  <= wr_data_i[31:0];
      buf_q[IDX_W'(wr_idx_i + 1'b1)]   <= wr_data_i[63:32];
    end
  end

  assign rd_data_o = buf_q;

endmodule

// File: rtl/ip_codma_read_machine.sv
// CODMA read machine: fetches a 2/4/8-word block over the shared bus
// into the local buffer, hands it to the write machine and waits.
// Optional grant-wait timeout: define CODMA_RD_TIMEOUT_EN.
module ip_codma_read_machine
  import ip_codma_states_pkg::*;
#(
  parameter int BUF_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [31:0]                src_addr_i,
  input  logic [3:0]                 size_i,
  input  logic                       stop_i,
  input  logic                       wr_done_i,
  output logic                       need_write_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [7:0]                 word_count_rd,
  output read_state_t                rd_state_r,
  output read_state_t                rd_state_next_s,
  output logic [BUF_WORDS-1:0][31:0] buf_data_o,
  BUS_IF.master                      bus_if
);

  localparam int IDX_W = $clog2(BUF_WORDS);

  read_state_t state_q, state_d;
  logic        need_write_q, done_q, error_q, req_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic [3:0]  size_q;
  logic [7:0]  words;
  logic        beat_ok, bus_err_act, tmo_hit;

  assign words       = size_words(size_q);
  assign bus_err_act = bus_if.error && (state_q == RD_ASK || state_q == RD_GRANTED);
  // A beat is taken only while reading, below the block size, and when
  // neither abort nor bus error overrides it.
  assign beat_ok     = (state_q == RD_GRANTED) && bus_if.rvalid && (cnt_q < words)
                       && !stop_i && !bus_if.error;

`ifdef CODMA_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Counts cycles spent waiting for grant; cleared outside RD_ASK.
  always_ff @(posedge clk_i) begin
    if (reset_i || state_q != RD_ASK) tmo_q <= '0;
    else                              tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == RD_ASK) && !bus_if.grant
                   && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_hit        = 1'b0;
`endif

  // Next state, with abort above bus error above normal flow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE:    if (start_i && size_legal(size_i)) state_d = RD_ASK;
      RD_ASK:     if (bus_if.grant) state_d = RD_GRANTED;
                  else if (tmo_hit) state_d = RD_IDLE;
      RD_GRANTED: if (beat_ok && (cnt_q + 8'd2 == words)) state_d = RD_HANDOFF;
      RD_HANDOFF: state_d = RD_WAIT_WR;
      RD_WAIT_WR: if (wr_done_i) state_d = RD_IDLE;
      default:    state_d = RD_IDLE;
    endcase
    if (bus_err_act) state_d = RD_IDLE;
    if (stop_i)      state_d = RD_IDLE;
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= RD_IDLE;
      need_write_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      req_q        <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
    end else begin
      state_q      <= state_d;
      need_write_q <= 1'b0;
      done_q       <= 1'b0;
      if (stop_i) begin
        req_q <= 1'b0;
      end else if (bus_err_act) begin
        req_q   <= 1'b0;
        error_q <= 1'b1;
      end else begin
        case (state_q)
          RD_IDLE: if (start_i) begin
            if (size_legal(size_i)) begin
              addr_q  <= src_addr_i;
              size_q  <= size_i;
              cnt_q   <= '0;
              error_q <= 1'b0;
              req_q   <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end
          RD_ASK: if (bus_if.grant) begin
            req_q <= 1'b0;
          end else if (tmo_hit) begin
            req_q   <= 1'b0;
            error_q <= 1'b1;
          end
          RD_GRANTED: if (beat_ok) begin
            cnt_q <= cnt_q + 8'd2;
            if (cnt_q + 8'd2 == words) need_write_q <= 1'b1;
          end
          RD_HANDOFF: ;
          RD_WAIT_WR: if (wr_done_i) done_q <= 1'b1;
          default:    error_q <= 1'b1;
        endcase
      end
    end
  end

  ip_codma_rd_buffer #(.BUF_WORDS(BUF_WORDS)) u_buf (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (beat_ok),
    .wr_idx_i  (cnt_q[IDX_W-1:0]),
    .wr_data_i (bus_if.rdata),
    .rd_data_o (buf_data_o)
  );

  assign bus_if.req      = req_q;
  assign bus_if.we       = 1'b0;
  assign bus_if.addr     = addr_q;
  assign bus_if.size     = size_q;
  assign need_write_o    = need_write_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign word_count_rd   = cnt_q;
  assign rd_state_r      = state_q;
  assign rd_state_next_s = state_d;

endmodule
